// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out transmitter.
// The PARITY state is only reachable when PISO_PARITY_EN is defined.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int   DEFAULT_WIDTH = 8;
    localparam logic IDLE_LEVEL    = 1'b0;

endpackage

// File: rtl/piso_bit_counter.sv
// Beat counter for one serial frame: cleared at load, advanced per data beat,
// with a flag marking the final data bit.
module piso_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count;

    // Return to zero after the final beat so the counter never runs past WIDTH-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

    assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load and shift_en pacing.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             lsb_first,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q;
    logic             dir_q;
    logic             done_q, done_d;
    logic             load_fire;
    logic             beat;
    logic             last;
`ifdef PISO_PARITY_EN
    logic             parity_q;
`endif

    assign load_fire = (state_q == IDLE) && load_valid;
    assign beat      = (state_q == SHIFT) && shift_en;

    piso_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (load_fire),
        .enable (beat),
        .last   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) state_d = SHIFT;
            end
            SHIFT: begin
                if (shift_en && last) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
            PARITY: begin
`ifdef PISO_PARITY_EN
                if (shift_en) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Direction and parity are frozen at load so later input changes cannot disturb the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            dir_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (load_fire) begin
            shift_q <= load_data;
            dir_q   <= lsb_first;
`ifdef PISO_PARITY_EN
            parity_q <= ^load_data;
`endif
        end else if (beat) begin
            shift_q <= dir_q ? (shift_q >> 1) : (shift_q << 1);
        end
    end

    always_comb begin
        serial_out = IDLE_LEVEL;
        case (state_q)
            SHIFT:   serial_out = dir_q ? shift_q[0] : shift_q[WIDTH-1];
`ifdef PISO_PARITY_EN
            PARITY:  serial_out = parity_q;
`endif
            default: serial_out = IDLE_LEVEL;
        endcase
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer against a bit-list reference model.
// Honours PISO_PARITY_EN to expect the trailing parity bit.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_data;
    logic         lsb_first;
    logic         shift_en;
    logic         serial_out;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .lsb_first  (lsb_first),
        .shift_en   (shift_en),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Transmits one frame starting at a negedge with the DUT in IDLE and returns
    // at the negedge of the done cycle. mode: 0 = no gaps, 1 = gap before every
    // beat, 2 = random gaps. intrude keeps a stray word on load_valid throughout.
    task automatic run_frame(input logic [W-1:0] data, input bit lsb, input int mode, input bit intrude);
        bit exp_bits[$];
        int n;
        int cycles;
        bit en;
        bit toggle;
        for (int k = 0; k < W; k++) exp_bits.push_back(lsb ? data[k] : data[W-1-k]);
        if (PAR == 1) exp_bits.push_back(($countones(data) % 2) == 1);
        n = exp_bits.size();

        load_valid = 1'b1;
        load_data  = data;
        lsb_first  = lsb;
        shift_en   = 1'($urandom % 2);
        @(negedge clk);
        cycles = 0;
        toggle = 1'b0;
        if (intrude) begin
            load_valid = 1'b1;
            load_data  = '1;
        end else begin
            load_valid = 1'b0;
            load_data  = W'($urandom);
        end
        lsb_first = 1'($urandom % 2);

        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < 64; g++) begin
                checks++;
                if (serial_out !== exp_bits[k])
                    $display("[TB] FAIL bit data=%h idx=%0d got %b want %b", data, k, serial_out, exp_bits[k]);
                checks++;
                if (busy !== 1'b1 || load_ready !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL frame_status data=%h idx=%0d got busy=%b ready=%b done=%b want 1 0 0",
                             data, k, busy, load_ready, done);
                end
                if (serial_out !== exp_bits[k]) errors++;
                case (mode)
                    0:       en = 1'b1;
                    1:       begin en = toggle; toggle = ~toggle; end
                    default: en = (($urandom % 3) != 0) || (g == 63);
                endcase
                shift_en = en;
                @(negedge clk);
                cycles++;
                if (en) break;
            end
        end

        shift_en = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b1 || serial_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_cycle data=%h got done=%b busy=%b ready=%b out=%b want 1 0 1 0",
                     data, done, busy, load_ready, serial_out);
        end
        if (mode == 1) begin
            checks++;
            if (cycles != 2 * n) begin
                errors++;
                $display("[TB] FAIL gap_latency got %0d cycles want %0d", cycles, 2 * n);
            end
        end
    endtask

    task automatic idle_cycle_check(input string name);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0 || serial_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s got done=%b ready=%b busy=%b out=%b want 0 1 0 0",
                     name, done, load_ready, busy, serial_out);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        lsb_first  = 1'b0;
        shift_en   = 1'b0;
        #12;
        checks++;
        if (serial_out !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values got out=%b ready=%b busy=%b done=%b want 0 1 0 0",
                     serial_out, load_ready, busy, done);
        end
        @(negedge clk);
        rst      = 1'b0;
        shift_en = 1'b1;
        idle_cycle_check("idle_after_reset");
        idle_cycle_check("idle_hold");
    endtask

    task automatic test_msb_first();
        run_frame(8'h0F, 1'b0, 0, 1'b0);
        idle_cycle_check("msb_done_one_cycle");
    endtask

    task automatic test_lsb_first();
        run_frame(8'h0F, 1'b1, 0, 1'b0);
        idle_cycle_check("lsb_done_one_cycle");
    endtask

    task automatic test_gaps();
        run_frame(8'hA5, 1'b0, 1, 1'b0);
        idle_cycle_check("gaps_done_one_cycle");
    endtask

    task automatic test_back_to_back();
        run_frame(8'h96, 1'b0, 0, 1'b1);
        run_frame(8'h3C, 1'b0, 0, 1'b0);
        idle_cycle_check("b2b_done_one_cycle");
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] word;
        word       = 8'hA5;
        load_valid = 1'b1;
        load_data  = word;
        lsb_first  = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (serial_out !== word[W-1-k]) begin
                errors++;
                $display("[TB] FAIL pre_reset_bit idx=%0d got %b want %b", k, serial_out, word[W-1-k]);
            end
            shift_en = 1'b1;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (serial_out !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset got out=%b ready=%b busy=%b done=%b want 0 1 0 0",
                     serial_out, load_ready, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) idle_cycle_check("no_done_after_reset");
        run_frame(8'h01, 1'b0, 0, 1'b0);
        idle_cycle_check("post_reset_done_one_cycle");
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        run_frame(8'h07, 1'b0, 0, 1'b0);
        idle_cycle_check("parity07_done_one_cycle");
        run_frame(8'h03, 1'b0, 1, 1'b0);
        idle_cycle_check("parity03_done_one_cycle");
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_frame(W'($urandom), 1'($urandom % 2), int'($urandom % 3), 1'b0);
            if (($urandom % 2) == 0) idle_cycle_check("random_idle");
        end
        idle_cycle_check("random_tail");
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_gaps();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
